// File: rtl/bus_region_pkg.sv
// Shared types and the default address map for the bus region controller.
package bus_region_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RDY  = 2'd3
  } state_t;

  localparam int DEF_NUM_REGIONS   = 4;
  localparam int DEF_ADDR_WIDTH    = 20;
  localparam int DEF_IO_ADDR_WIDTH = 16;
  localparam int DEF_WAIT_WIDTH    = 4;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] base;
    logic [DEF_ADDR_WIDTH-1:0] mask;
    logic                      is_io;
    logic [DEF_WAIT_WIDTH-1:0] waits;
  } region_cfg_t;

  // Default map: low RAM, high ROM, a 16-port I/O block at 0xFF00, a
  // 512-port I/O block at 0x1C00.
  localparam logic [DEF_ADDR_WIDTH-1:0] DEF_BASE_ADDR [DEF_NUM_REGIONS] =
    '{20'h00000, 20'h80000, 20'h0FF00, 20'h01C00};
  localparam logic [DEF_ADDR_WIDTH-1:0] DEF_ADDR_MASK [DEF_NUM_REGIONS] =
    '{20'h80000, 20'h80000, 20'h0FFF0, 20'h0FE00};
  localparam logic [DEF_NUM_REGIONS-1:0] DEF_IS_IO = 4'b1100;
  localparam logic [DEF_WAIT_WIDTH-1:0] DEF_WAIT_STATES [DEF_NUM_REGIONS] =
    '{4'd0, 4'd1, 4'd2, 4'd3};

  // Bundles one entry of the default map into a single record.
  function automatic region_cfg_t default_cfg(input int idx);
    region_cfg_t cfg;
    cfg.base  = DEF_BASE_ADDR[idx];
    cfg.mask  = DEF_ADDR_MASK[idx];
    cfg.is_io = DEF_IS_IO[idx];
    cfg.waits = DEF_WAIT_STATES[idx];
    return cfg;
  endfunction

endpackage

// File: rtl/bus_region_controller_if.sv
// Processor-side bus between the 8088 pins and the region controller.
interface bus_region_controller_if
  import bus_region_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
);
  logic                   ALE;
  logic                   IOM;
  logic                   RD;
  logic                   WR;
  logic [ADDR_WIDTH-1:0]  ADDR_IN;
  logic [ADDR_WIDTH-1:0]  Address;
  logic [NUM_REGIONS-1:0] CS;
  logic                   READY;
  logic                   BUS_ERROR;

  modport master (
    output ALE, IOM, RD, WR, ADDR_IN,
    input  Address, CS, READY, BUS_ERROR
  );

  modport slave (
    input  ALE, IOM, RD, WR, ADDR_IN,
    output Address, CS, READY, BUS_ERROR
  );
endinterface

// File: rtl/bus_region_controller_decoder.sv
// Combinational base/mask region decoder with lowest-index priority.
module region_decoder
  import bus_region_pkg::*;
#(
  parameter int NUM_REGIONS   = DEF_NUM_REGIONS,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int IO_ADDR_WIDTH = DEF_IO_ADDR_WIDTH,
  parameter int SEL_W         = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR [NUM_REGIONS] = DEF_BASE_ADDR,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK [NUM_REGIONS] = DEF_ADDR_MASK,
  parameter logic [NUM_REGIONS-1:0] IS_IO = DEF_IS_IO
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   iom,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [SEL_W-1:0]       sel,
  output logic                   hit,
  output logic                   overlap
);

  // I/O cycles only drive the low port-address bits, so upper bits are ignored.
  localparam logic [ADDR_WIDTH-1:0] IO_KEEP =
    ADDR_WIDTH'((64'd1 << IO_ADDR_WIDTH) - 64'd1);

  logic [NUM_REGIONS-1:0] match;

  // Raw per-region match against base/mask and address space.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (IS_IO[i]) begin
        match[i] = ((addr & ADDR_MASK[i] & IO_KEEP) ==
                    (BASE_ADDR[i] & ADDR_MASK[i] & IO_KEEP)) && iom;
      end else begin
        match[i] = ((addr & ADDR_MASK[i]) ==
                    (BASE_ADDR[i] & ADDR_MASK[i])) && !iom;
      end
    end
  end

  // Priority select: scanning downwards leaves the lowest matching index.
  always_comb begin
    cs  = '0;
    sel = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        cs     = '0;
        cs[i]  = 1'b1;
        sel    = SEL_W'(i);
      end
    end
  end

  assign hit     = |match;
  assign overlap = |(match & (match - NUM_REGIONS'(1)));

endmodule

// File: rtl/bus_region_controller.sv
// Address latch, region chip-select and READY wait-state generator.
module bus_region_controller
  import bus_region_pkg::*;
#(
  parameter int NUM_REGIONS   = DEF_NUM_REGIONS,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int IO_ADDR_WIDTH = DEF_IO_ADDR_WIDTH,
  parameter int WAIT_WIDTH    = DEF_WAIT_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR [NUM_REGIONS] = DEF_BASE_ADDR,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK [NUM_REGIONS] = DEF_ADDR_MASK,
  parameter logic [NUM_REGIONS-1:0] IS_IO = DEF_IS_IO,
  parameter logic [WAIT_WIDTH-1:0] WAIT_STATES [NUM_REGIONS] = DEF_WAIT_STATES
) (
  input logic CLK,
  input logic RESET,
  bus_region_controller_if.slave bus
);

  // state | meaning
  // IDLE  | no bus cycle; waiting for ALE
  // ADDR  | address latched; waiting for RD or WR strobe
  // WAIT  | inserting Tw cycles, READY low
  // RDY   | READY high; waiting for strobes to release

  localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   hit_q, hit_d;
  logic [WAIT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [NUM_REGIONS-1:0] dec_cs;
  logic [SEL_W-1:0]       dec_sel;
  logic                   dec_hit;
  logic                   dec_overlap;
  logic [WAIT_WIDTH-1:0]  sel_waits;
  logic                   take_addr;

  region_decoder #(
    .NUM_REGIONS  (NUM_REGIONS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .IO_ADDR_WIDTH(IO_ADDR_WIDTH),
    .SEL_W        (SEL_W),
    .BASE_ADDR    (BASE_ADDR),
    .ADDR_MASK    (ADDR_MASK),
    .IS_IO        (IS_IO)
  ) u_dec (
    .addr   (bus.ADDR_IN),
    .iom    (bus.IOM),
    .cs     (dec_cs),
    .sel    (dec_sel),
    .hit    (dec_hit),
    .overlap(dec_overlap)
  );

  // Wait count of the region captured at the last address latch.
  always_comb begin
    sel_waits = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (SEL_W'(i) == sel_q) sel_waits = WAIT_STATES[i];
    end
  end

  // Next-state, counter and latch control.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cs_d      = cs_q;
    sel_d     = sel_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    take_addr = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ALE) begin
          take_addr = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (bus.ALE) begin
          // Aborted cycle: follow the new address, keep waiting for a strobe.
          take_addr = 1'b1;
        end else if (!bus.RD || !bus.WR) begin
          // Both strobes low is handled as a write but flagged.
          err_d = !bus.RD && !bus.WR;
          if (!hit_q || sel_waits == '0) begin
            state_d = RDY;
          end else begin
            cnt_d   = sel_waits;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= WAIT_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = RDY;
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      RDY: begin
        if (bus.RD && bus.WR) begin
          if (bus.ALE) begin
            take_addr = 1'b1;
            state_d   = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_addr) begin
      addr_d = bus.ADDR_IN;
      cs_d   = dec_cs;
      sel_d  = dec_sel;
      hit_d  = dec_hit;
      err_d  = !dec_hit || dec_overlap;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cs_q    <= '0;
      sel_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      sel_q   <= sel_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.Address   = addr_q;
  assign bus.CS        = cs_q;
  assign bus.READY     = (state_q != WAIT);
  assign bus.BUS_ERROR = err_q;

endmodule
